// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for a simple core.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module fetch_exec_sequencer #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  input  logic               dec_we,
  input  logic               is_mem,
  input  logic               is_store,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               rf_we,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALTED    = 3'd5;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic            lat_dec_we;
  logic            lat_is_mem;
  logic            lat_is_store;
  logic            lat_br_taken;
  logic [PC_W-1:0] lat_br_target;

  // Strobes depend only on the registered state; reset masks them so a pending access aborts at once.
  assign imem_req  = (state == FETCH) && !reset;
  assign dmem_req  = (state == MEMORY) && !reset;
  assign dmem_we   = (state == MEMORY) && lat_is_store && !reset;
  assign rf_we     = (state == WRITEBACK) && lat_dec_we && !(lat_is_mem && lat_is_store) && !reset;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      lat_dec_we    <= 1'b0;
      lat_is_mem    <= 1'b0;
      lat_is_store  <= 1'b0;
      lat_br_taken  <= 1'b0;
      lat_br_target <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          lat_dec_we   <= dec_we;
          lat_is_mem   <= is_mem;
          lat_is_store <= is_store;
          state        <= EXECUTE;
        end
        EXECUTE: begin
          lat_br_taken  <= branch_taken;
          lat_br_target <= branch_target;
          state         <= lat_is_mem ? MEMORY : WRITEBACK;
        end
        MEMORY: begin
          if (dmem_ready) state <= WRITEBACK;
        end
        WRITEBACK: begin
          pc    <= lat_br_taken ? lat_br_target : pc + PC_ONE;
          state <= halt ? HALTED : FETCH;
        end
        HALTED: begin
          if (!halt) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) retired <= '0;
    else if (state == WRITEBACK) retired <= retired + CNT_ONE;
  end
`else
  assign retired = '0;
`endif

endmodule
